// File: rtl/pipe_hazard_if.sv
// Purpose: bundles the hazard-controller signal set shared between the pipeline
// datapath (master side) and the sequencing controller (slave side).
// Ports (as interface signals):
//   master -> slave : ex_valid_i, predict_miss_i, ex_is_load_i, ex_wa_i[4:0],
//                     id_rs1_i[4:0], id_rs2_i[4:0], id_rs1_used_i, id_rs2_used_i,
//                     dmem_busy_i
//   slave -> master : pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
//                     if_id_flush_o, id_ex_flush_o, redirect_o,
//                     stall_cnt_o[CNT_W-1:0], flush_cnt_o[CNT_W-1:0], err_o
interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    logic             ex_valid_i;
    logic             predict_miss_i;
    logic             ex_is_load_i;
    logic [4:0]       ex_wa_i;
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_rs1_used_i;
    logic             id_rs2_used_i;
    logic             dmem_busy_i;

    logic             pc_stall_o;
    logic             if_id_stall_o;
    logic             id_ex_stall_o;
    logic             ex_mem_stall_o;
    logic             if_id_flush_o;
    logic             id_ex_flush_o;
    logic             redirect_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             err_o;

    modport master (
        output ex_valid_i, predict_miss_i, ex_is_load_i, ex_wa_i,
               id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, dmem_busy_i,
        input  pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
               if_id_flush_o, id_ex_flush_o, redirect_o,
               stall_cnt_o, flush_cnt_o, err_o
    );

    modport slave (
        input  ex_valid_i, predict_miss_i, ex_is_load_i, ex_wa_i,
               id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, dmem_busy_i,
        output pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
               if_id_flush_o, id_ex_flush_o, redirect_o,
               stall_cnt_o, flush_cnt_o, err_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline sequencing controller for the 5-stage core. Resolves data
// memory busy, branch mispredict and load-use hazards (priority BUSY > MISS > LU)
// into per-stage stall/flush enables and a PC redirect strobe. Also keeps
// saturating stall/redirect counters and a sticky data-memory timeout flag.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous reset, active high
//   bus  - pipe_hazard_if.slave: hazard inputs from ID/EX/MEM, stall/flush/
//          redirect controls, performance counters and err_o back to the core
// Outputs are combinational from registered state and current inputs.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipe_hazard_if.slave  bus
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FC_W-1:0]   r_fcnt;
    logic [FC_W-1:0]   w_fcnt_nxt;
    logic [WC_W-1:0]   r_wcnt;
    logic              r_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_busy;
    logic w_miss;
    logic w_lu;
    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_id_ex_stall;
    logic w_ex_mem_stall;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_redirect;

    assign w_busy = bus.dmem_busy_i;
    assign w_miss = bus.predict_miss_i & bus.ex_valid_i;
    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    assign w_lu   = bus.ex_valid_i & bus.ex_is_load_i & (bus.ex_wa_i != 5'd0) &
                    ((bus.id_rs1_used_i & (bus.id_rs1_i == bus.ex_wa_i)) |
                     (bus.id_rs2_used_i & (bus.id_rs2_i == bus.ex_wa_i)));

    always_comb begin
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_ex_mem_stall = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_redirect     = 1'b0;
        w_state_nxt    = r_state;
        w_fcnt_nxt     = r_fcnt;

        if (rst) begin
            // Reset keeps bubbles flowing into the front of the pipe.
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_state_nxt   = ST_RUN;
            w_fcnt_nxt    = '0;
        end else if (w_busy) begin
            // Whole pipe frozen; the flush down-counter is frozen with it and
            // any masked MISS/LU re-presents because EX is held.
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_stall  = 1'b1;
            w_ex_mem_stall = 1'b1;
            if (r_state != ST_FLUSH) begin
                w_state_nxt = ST_MEMWAIT;
            end
        end else if (r_state == ST_FLUSH) begin
            // EX already holds a bubble from the redirect cycle, so MISS is
            // not acted on here.
            w_if_id_flush = 1'b1;
            if (r_fcnt == FC_W'(1)) begin
                w_state_nxt = ST_RUN;
                w_fcnt_nxt  = '0;
            end else begin
                w_fcnt_nxt = r_fcnt - 1'b1;
            end
        end else begin
            // RUN, or MEMWAIT on the cycle busy drops: evaluated as RUN.
            w_state_nxt = ST_RUN;
            if (w_miss) begin
                w_redirect    = 1'b1;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    w_state_nxt = ST_FLUSH;
                    w_fcnt_nxt  = FC_W'(FLUSH_CYCLES - 1);
                end
            end else if (w_lu) begin
                w_pc_stall    = 1'b1;
                w_if_id_stall = 1'b1;
                w_id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_fcnt      <= '0;
            r_wcnt      <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            // wcnt tracks consecutive busy cycles; err latches on the busy
            // cycle that brings it to MEM_TIMEOUT.
            if (w_busy) begin
                if (r_wcnt != WC_W'(MEM_TIMEOUT)) begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
                if (r_wcnt >= WC_W'(MEM_TIMEOUT - 1)) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_wcnt <= '0;
            end
            if (w_pc_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_redirect) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign bus.pc_stall_o     = w_pc_stall;
    assign bus.if_id_stall_o  = w_if_id_stall;
    assign bus.id_ex_stall_o  = w_id_ex_stall;
    assign bus.ex_mem_stall_o = w_ex_mem_stall;
    assign bus.if_id_flush_o  = w_if_id_flush;
    assign bus.id_ex_flush_o  = w_id_ex_flush;
    assign bus.redirect_o     = w_redirect;
    // Status reads as cleared for the whole time reset is held.
    assign bus.stall_cnt_o    = rst ? '0 : r_stall_cnt;
    assign bus.flush_cnt_o    = rst ? '0 : r_flush_cnt;
    assign bus.err_o          = r_err & ~rst;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    localparam int FC   = 3;
    localparam int MT   = 4;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst;

    pipe_hazard_if #(.CNT_W(CW)) ph ();

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ph)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] stl;   // pc, if_id, id_ex, ex_mem
        logic [2:0] fl;    // if_id_flush, id_ex_flush, redirect
        int         sc;
        int         fc;
        logic       err;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: remaining forced IF/ID flush cycles, length of the
    // current busy run, counters and sticky error.
    int m_fleft = 0;
    int m_brun  = 0;
    int m_sc    = 0;
    int m_fc    = 0;
    bit m_err   = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit pm, input bit ld,
                        input int wa, input int r1, input int r2,
                        input bit u1, input bit u2, input bit bz, input string tag);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        rst               = r;
        ph.ex_valid_i     = v;
        ph.predict_miss_i = pm;
        ph.ex_is_load_i   = ld;
        ph.ex_wa_i        = wa[4:0];
        ph.id_rs1_i       = r1[4:0];
        ph.id_rs2_i       = r2[4:0];
        ph.id_rs1_used_i  = u1;
        ph.id_rs2_used_i  = u2;
        ph.dmem_busy_i    = bz;

        e.tag = tag;
        e.stl = 4'b0000;
        e.fl  = 3'b000;
        if (r) begin
            e.fl  = 3'b110;
            e.sc  = 0;
            e.fc  = 0;
            e.err = 1'b0;
            m_fleft = 0; m_brun = 0; m_sc = 0; m_fc = 0; m_err = 0;
        end else begin
            e.sc  = m_sc;
            e.fc  = m_fc;
            e.err = m_err;
            lu = v && ld && (wa != 0) && ((u1 && r1 == wa) || (u2 && r2 == wa));
            if (bz) begin
                e.stl = 4'b1111;
                m_brun++;
                if (m_brun >= MT) m_err = 1;
                if (m_sc < CMAX) m_sc++;
            end else begin
                m_brun = 0;
                if (m_fleft > 0) begin
                    e.fl = 3'b100;
                    m_fleft--;
                end else if (v && pm) begin
                    e.fl = 3'b111;
                    m_fleft = FC - 1;
                    if (m_fc < CMAX) m_fc++;
                end else if (lu) begin
                    e.stl = 4'b1100;
                    e.fl  = 3'b010;
                    if (m_sc < CMAX) m_sc++;
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    // Monitor: outputs are valid every cycle, compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".stall"}, int'({ph.pc_stall_o, ph.if_id_stall_o,
                                             ph.id_ex_stall_o, ph.ex_mem_stall_o}), int'(e.stl));
                chk({e.tag, ".flush"}, int'({ph.if_id_flush_o, ph.id_ex_flush_o,
                                             ph.redirect_o}), int'(e.fl));
                chk({e.tag, ".stall_cnt"}, int'(ph.stall_cnt_o), e.sc);
                chk({e.tag, ".flush_cnt"}, int'(ph.flush_cnt_o), e.fc);
                chk({e.tag, ".err"}, int'(ph.err_o), int'(e.err));
            end
        end
    end

    initial begin
        bit busy_run;
        rst = 1'b1;
        ph.ex_valid_i = 0; ph.predict_miss_i = 0; ph.ex_is_load_i = 0;
        ph.ex_wa_i = 0; ph.id_rs1_i = 0; ph.id_rs2_i = 0;
        ph.id_rs1_used_i = 0; ph.id_rs2_used_i = 0; ph.dmem_busy_i = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        idle(1, "idle");

        // Load-use through rs2, then x0 destination (no hazard).
        step(0, 1, 0, 1, 5, 0, 5, 0, 1, 0, "lu");
        idle(2, "lu_after");
        step(0, 1, 0, 1, 0, 0, 3, 1, 0, 0, "lu_x0");
        idle(1, "lu_x0_after");

        // Mispredict: redirect once, IF/ID flushed for FC cycles.
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "miss");
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "miss_in_flush");
        idle(3, "miss_after");

        // Busy masks a held mispredict; also reaches the timeout.
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, "busy_miss");
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "busy_miss_rel");
        idle(3, "busy_miss_after");

        // Longer busy run, err stays sticky until reset.
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "timeout");
        idle(3, "err_sticky");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "err_rst");
        idle(1, "err_cleared");

        // Reset during FLUSH.
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "miss2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_in_flush");
        idle(2, "after_rst_flush");

        // Busy inside FLUSH freezes the flush count.
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "miss3");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "busy_in_flush");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "busy_in_flush");
        idle(3, "flush_resume");

        // Randomized traffic.
        busy_run = 0;
        for (int i = 0; i < 1500; i++) begin
            bit r;
            if ($urandom_range(0, 99) < 15) busy_run = ~busy_run;
            r = ($urandom_range(0, 199) == 0);
            step(r, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 5, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 busy_run && ($urandom_range(0, 9) < 9), "rand");
        end

        idle(1, "drain");
        repeat (3) @(posedge clk);
        chk("queue_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
